// File: rtl/pipe_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard, redirect and mul/div
// handshakes become per-stage write-enables and bubbles. Optional PIPE_PERF_CNT_EN adds perf counters.
module pipe_sequencer #(
    parameter int unsigned MD_MAX_CYC = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             stall,
    input  logic             stall2,
    input  logic             id_redirect,
    input  logic             md_start,
    input  logic             md_done,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exme_we,
    output logic             exme_flush,
    output logic             md_busy,
    output logic             md_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_md
`endif
);

    localparam int unsigned MD_CNT_W = $clog2(MD_MAX_CYC + 1);

    if (MD_MAX_CYC < 2 || CNT_W < 1) begin : g_bad_param
        $error("pipe_sequencer: MD_MAX_CYC must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL2 = 2'd1,
        ST_MDWAIT = 2'd2
    } state_e;

    state_e              state, state_nxt;
    logic [MD_CNT_W-1:0] md_cnt, md_cnt_nxt;
    logic                timeout_set;

    // State, mul/div cycle counter and sticky timeout flag
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= ST_RUN;
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (timeout_set) begin
                md_timeout <= 1'b1;
            end
        end
    end

    // Next-state decode; md_start outranks stall, which outranks redirect
    always_comb begin
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        timeout_set = 1'b0;
        case (state)
            ST_RUN: begin
                if (md_start) begin
                    state_nxt  = ST_MDWAIT;
                    md_cnt_nxt = MD_CNT_W'(1);
                end else if (stall || stall2) begin
                    state_nxt = stall2 ? ST_STALL2 : ST_RUN;
                end
            end
            ST_STALL2: begin
                state_nxt = ST_RUN;
            end
            ST_MDWAIT: begin
                if (md_done) begin
                    state_nxt  = ST_RUN;
                    md_cnt_nxt = '0;
                end else if (md_cnt == MD_CNT_W'(MD_MAX_CYC)) begin
                    // Overrun: abandon the op and resume the pipeline
                    state_nxt   = ST_RUN;
                    md_cnt_nxt  = '0;
                    timeout_set = 1'b1;
                end else begin
                    md_cnt_nxt = md_cnt + MD_CNT_W'(1);
                end
            end
            default: begin
                state_nxt  = ST_RUN;
                md_cnt_nxt = '0;
            end
        endcase
    end

    // Per-stage enables and bubbles; reset holds every stage flushed
    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        exme_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exme_flush = 1'b0;
        md_busy    = 1'b0;
        if (!clrn) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_we    = 1'b0;
            exme_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exme_flush = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (md_start) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_we    = 1'b0;
                        exme_we    = 1'b0;
                        exme_flush = 1'b1;
                    end else if (stall || stall2) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (id_redirect) begin
                        ifid_flush = 1'b1;
                    end
                end
                ST_STALL2: begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end
                ST_MDWAIT: begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_we    = 1'b0;
                    md_busy    = 1'b1;
                    exme_we    = md_done;
                    exme_flush = !md_done;
                end
                default: begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Free-running wrap-around performance counters
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_md    <= '0;
        end else begin
            if (!pc_we && state != ST_MDWAIT) begin
                perf_stall <= perf_stall + CNT_W'(1);
            end
            if (ifid_flush) begin
                perf_flush <= perf_flush + CNT_W'(1);
            end
            if (state == ST_MDWAIT) begin
                perf_md <= perf_md + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: a vector table for single-cycle decode plus
// hand sequences for reset, mul/div abort and timeout (second instance, MD_MAX_CYC=4).
module tb_pipe_sequencer;

    localparam int unsigned CNT_W = 32;

    logic clk, clrn;
    logic stall, stall2, id_redirect, md_start, md_done;

    logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exme_we, exme_flush;
    logic md_busy, md_timeout;
    logic pc_we4, ifid_we4, ifid_flush4, idex_we4, idex_flush4, exme_we4, exme_flush4;
    logic md_busy4, md_timeout4;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall, perf_flush, perf_md;
    logic [CNT_W-1:0] perf_stall4, perf_flush4, perf_md4;
`endif

    logic [7:0] obs, obs4;
    assign obs  = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exme_we, exme_flush, md_busy};
    assign obs4 = {pc_we4, ifid_we4, ifid_flush4, idex_we4, idex_flush4, exme_we4, exme_flush4, md_busy4};

    pipe_sequencer #(.MD_MAX_CYC(64), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .clrn(clrn), .stall(stall), .stall2(stall2),
        .id_redirect(id_redirect), .md_start(md_start), .md_done(md_done),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_flush(idex_flush), .exme_we(exme_we),
        .exme_flush(exme_flush), .md_busy(md_busy), .md_timeout(md_timeout)
`ifdef PIPE_PERF_CNT_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_md(perf_md)
`endif
    );

    pipe_sequencer #(.MD_MAX_CYC(4), .CNT_W(CNT_W)) u_dut4 (
        .clk(clk), .clrn(clrn), .stall(stall), .stall2(stall2),
        .id_redirect(id_redirect), .md_start(md_start), .md_done(md_done),
        .pc_we(pc_we4), .ifid_we(ifid_we4), .ifid_flush(ifid_flush4),
        .idex_we(idex_we4), .idex_flush(idex_flush4), .exme_we(exme_we4),
        .exme_flush(exme_flush4), .md_busy(md_busy4), .md_timeout(md_timeout4)
`ifdef PIPE_PERF_CNT_EN
        , .perf_stall(perf_stall4), .perf_flush(perf_flush4), .perf_md(perf_md4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Input order {stall, stall2, id_redirect, md_start, md_done};
    // output order {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exme_we, exme_flush, md_busy}
    typedef struct {
        logic [4:0] in;
        logic [7:0] exp;
    } vec_t;

    localparam logic [7:0] O_IDLE  = 8'b1101_0100;
    localparam logic [7:0] O_STALL = 8'b0001_1100;
    localparam logic [7:0] O_RESET = 8'b0010_1010;

    vec_t vecs[19];

    task automatic apply(input logic [4:0] in);
        {stall, stall2, id_redirect, md_start, md_done} = in;
    endtask

    initial begin
        vecs[0]  = '{5'b00000, O_IDLE};
        vecs[1]  = '{5'b10000, O_STALL};
        vecs[2]  = '{5'b00000, O_IDLE};
        vecs[3]  = '{5'b11000, O_STALL};
        vecs[4]  = '{5'b00100, O_STALL};       // STALL2: redirect ignored
        vecs[5]  = '{5'b00000, O_IDLE};
        vecs[6]  = '{5'b00100, 8'b1111_0100};  // redirect squashes IF/ID
        vecs[7]  = '{5'b10100, O_STALL};       // stall beats redirect
        vecs[8]  = '{5'b00000, O_IDLE};
        vecs[9]  = '{5'b01000, O_STALL};       // stall2 alone implies stall
        vecs[10] = '{5'b00010, O_STALL};       // md_start ignored in STALL2
        vecs[11] = '{5'b00010, 8'b0000_0010};  // md_start in RUN
        vecs[12] = '{5'b10100, 8'b0000_0011};  // MDWAIT ignores stall/redirect
        vecs[13] = '{5'b00000, 8'b0000_0011};
        vecs[14] = '{5'b00000, 8'b0000_0011};
        vecs[15] = '{5'b00000, 8'b0000_0011};
        vecs[16] = '{5'b00001, 8'b0000_0101};  // md_done: result enters ME
        vecs[17] = '{5'b00000, O_IDLE};
        vecs[18] = '{5'b00001, O_IDLE};        // md_done in RUN ignored

        clrn = 1'b0;
        apply(5'b00000);
        #3;
        check("reset_outputs", 32'(obs), 32'(O_RESET));
        check("reset_timeout", 32'(md_timeout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        #2;
        check("release_idle", 32'(obs), 32'(O_IDLE));

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            apply(vecs[i].in);
            #2;
            check($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
            check($sformatf("vec%0d_timeout", i), 32'(md_timeout), 32'd0);
        end

        @(negedge clk);
        apply(5'b00000);
        #2;
`ifdef PIPE_PERF_CNT_EN
        check("perf_stall", perf_stall, 32'd7);
        check("perf_flush", perf_flush, 32'd1);
        check("perf_md", perf_md, 32'd5);
`endif
        // The MD_MAX_CYC=4 copy overran during vectors 12..15
        check("dut4_timeout_after_table", 32'(md_timeout4), 32'd1);

        // Reset in the middle of MDWAIT aborts the op
        @(negedge clk);
        apply(5'b00010);
        #2;
        check("abort_start", 32'(obs), 32'(8'b0000_0010));
        @(negedge clk);
        apply(5'b00000);
        #2;
        check("abort_busy", 32'(md_busy), 32'd1);
        @(posedge clk);
        #2;
        clrn = 1'b0;
        #1;
        check("midcycle_reset_outputs", 32'(obs), 32'(O_RESET));
        check("midcycle_reset_clears_timeout", 32'(md_timeout4), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        #2;
        check("abort_back_to_run", 32'(obs), 32'(O_IDLE));
`ifdef PIPE_PERF_CNT_EN
        check("perf_md_reset", perf_md, 32'd0);
`endif

        // Timeout on the MD_MAX_CYC=4 instance
        @(negedge clk);
        apply(5'b00010);
        #2;
        check("to_start", 32'(obs4), 32'(8'b0000_0010));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            apply(5'b00000);
            #2;
            check($sformatf("to_wait%0d", k), 32'(obs4), 32'(8'b0000_0011));
            check($sformatf("to_wait%0d_flag", k), 32'(md_timeout4), 32'd0);
        end
        @(negedge clk);
        #2;
        check("to_back_to_run", 32'(obs4), 32'(O_IDLE));
        check("to_flag_set", 32'(md_timeout4), 32'd1);
        check("md64_still_busy", 32'(md_busy), 32'd1);

        @(negedge clk);
        apply(5'b00001);
        #2;
        check("md64_done", 32'(obs), 32'(8'b0000_0101));
        check("to_ignores_done", 32'(obs4), 32'(O_IDLE));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            apply(5'b00000);
            #2;
            check($sformatf("to_sticky%0d", k), 32'(md_timeout4), 32'd1);
        end
        @(negedge clk);
        apply(5'b10000);
        #2;
        check("to_run_stall", 32'(obs4), 32'(O_STALL));
`ifdef PIPE_PERF_CNT_EN
        check("perf_md4", perf_md4, 32'd4);
`endif

        @(negedge clk);
        apply(5'b00000);
        clrn = 1'b0;
        #2;
        check("to_cleared_by_reset", 32'(md_timeout4), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        #2;
        check("final_idle", 32'(obs4), 32'(O_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
